// File: rtl/arm_mem_pkg.sv
// Shared encodings and decode helpers for the MEM-stage data memory.
package arm_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Misaligned half/word or the reserved size encoding.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = lsb[0];
      SZ_WORD: access_err = (lsb != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lsb);
    case (size)
      SZ_BYTE: lane_enables = 4'b0001 << lsb;
      SZ_HALF: lane_enables = lsb[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_enables = 4'b1111;
      default: lane_enables = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte-lane write enables; synchronous write,
// combinational read. Contents are deliberately not reset.
module dmem_array #(
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [2**IDX_W];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressed data memory with valid/ready request, programmable wait
// states and a one-cycle response pulse; sized/extended loads, lane stores.
module data_mem_unit #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  import arm_mem_pkg::*;

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        err;
  logic [3:0]  lane_be;
  logic [3:0]  array_we;
  logic [31:0] array_wdata;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign accept = req_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign err     = access_err(size_q, addr_q[1:0]);
  assign lane_be = lane_enables(size_q, addr_q[1:0]);

  // Store commits on the edge closing RESP; reset forces IDLE first, discarding it.
  always_comb begin
    array_we    = '0;
    array_wdata = wdata_q;
    if (state_q == ST_RESP && we_q && !err) array_we = lane_be;
    case (size_q)
      SZ_BYTE: array_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: array_wdata = {2{wdata_q[15:0]}};
      default: array_wdata = wdata_q;
    endcase
  end

  dmem_array #(
    .IDX_W(ADDR_W - 2)
  ) u_array (
    .clk  (clk),
    .we   (array_we),
    .addr (addr_q[ADDR_W-1:2]),
    .wdata(array_wdata),
    .rdata(rd_word)
  );

  always_comb begin
    rd_byte = '0;
    case (addr_q[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = '0;
    endcase
    rd_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (size_q)
      SZ_BYTE: load_data = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_data = {{16{signed_q & rd_half[15]}}, rd_half};
      SZ_WORD: load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_err   = (state_q == ST_RESP) && err;
  assign rsp_rdata = (state_q == ST_RESP && !we_q && !err) ? load_data : '0;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench: table of accesses against a WAIT_CYCLES=1 instance, plus
// reset-abort and back-to-back handshake sequences on a WAIT_CYCLES=0 instance.
module tb_data_mem_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_req_ready, a_req_we = 1'b0, a_req_signed = 1'b0;
  logic [1:0]  a_req_size = 2'b00;
  logic [11:0] a_req_addr = '0;
  logic [31:0] a_req_wdata = '0, a_rsp_rdata;
  logic        a_rsp_valid, a_rsp_err, a_busy;

  logic        b_req_valid = 1'b0, b_req_ready, b_req_we = 1'b0, b_req_signed = 1'b0;
  logic [1:0]  b_req_size = 2'b10;
  logic [11:0] b_req_addr = '0;
  logic [31:0] b_req_wdata = '0, b_rsp_rdata;
  logic        b_rsp_valid, b_rsp_err, b_busy;

  data_mem_unit #(.ADDR_W(12), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_size(a_req_size), .req_signed(a_req_signed),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .busy(a_busy)
  );

  data_mem_unit #(.ADDR_W(12), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_signed(b_req_signed),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .busy(b_busy)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_access(input vec_t v, input string tag);
    int  lat;
    bit  got;
    @(negedge clk);
    chk({tag, " ready"}, 32'(a_req_ready), 32'd1);
    a_req_valid  = 1'b1;
    a_req_we     = v.we;
    a_req_size   = v.size;
    a_req_signed = v.sgn;
    a_req_addr   = v.addr;
    a_req_wdata  = v.wdata;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (a_rsp_valid) got = 1;
    end
    chk({tag, " latency"}, 32'(lat), 32'd2);
    if (got) begin
      chk({tag, " rdata"}, a_rsp_rdata, v.exp_rdata);
      chk({tag, " err"}, 32'(a_rsp_err), 32'(v.exp_err));
      chk({tag, " busy_in_resp"}, 32'(a_busy), 32'd1);
      @(negedge clk);
      chk({tag, " rdata_cleared"}, a_rsp_rdata, 32'd0);
      chk({tag, " flags_after"}, 32'({a_rsp_valid, a_rsp_err, a_busy, a_req_ready}), 32'b0001);
    end
  endtask

  initial begin
    int spurious;
    vecs.push_back('{1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        32'hFFFFFFDE, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        32'h000000DE, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 12'h010, 32'h0,        32'hFFFFBEEF, 1'b0});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 12'h011, 32'hFFFFFF5A, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDEAD5AEF, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 12'h013, 32'h0000FFFF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 12'h012, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'b11, 1'b0, 12'h000, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 12'h011, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        32'hDEAD5AEF, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 12'h010, 32'h0,        32'h00005AEF, 1'b0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 12'h016, 32'hABCD8001, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b0, 12'h016, 32'h0,        32'h00008001, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 12'h016, 32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 12'h020, 32'h11223344, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 12'h021, 32'h0,        32'h00000033, 1'b0});
    vecs.push_back('{1'b1, 2'b11, 1'b0, 12'h020, 32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 12'h020, 32'h0,        32'h11223344, 1'b0});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 12'hFFC, 32'hA5A50F0F, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 12'hFFF, 32'h0,        32'hFFFFFFA5, 1'b0});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 12'hFFC, 32'h0,        32'h0000000F, 1'b0});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 12'hFFE, 32'h0,        32'hFFFFA5A5, 1'b0});

    repeat (3) @(negedge clk);
    chk("reset a flags", 32'({a_rsp_valid, a_rsp_err, a_busy, a_req_ready}), 32'b0001);
    chk("reset a rdata", a_rsp_rdata, 32'd0);
    chk("reset b flags", 32'({b_rsp_valid, b_rsp_err, b_busy, b_req_ready}), 32'b0001);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) do_access(vecs[i], $sformatf("vec%0d", i));

    // Store aborted by reset while waiting.
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_size = 2'b10;
    a_req_addr = 12'h020; a_req_wdata = 32'h12345678;
    @(posedge clk);
    #1 a_req_valid = 1'b0;
    @(negedge clk);
    chk("abort in_wait", 32'({a_rsp_valid, a_busy, a_req_ready}), 32'b010);
    rst = 1'b1;
    #1 chk("abort reset_flags", 32'({a_rsp_valid, a_busy, a_req_ready}), 32'b001);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_rsp_valid) spurious++;
    end
    chk("abort no_rsp", 32'(spurious), 32'd0);
    do_access('{1'b0, 2'b10, 1'b0, 12'h020, 32'h0, 32'h11223344, 1'b0}, "abort reload");

    // Zero wait states with request held: accept every other cycle.
    @(negedge clk);
    b_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b cyc%0d", i), 32'({b_rsp_valid, b_busy, b_req_ready}),
          (i % 2 == 0) ? 32'b001 : 32'b110);
      @(negedge clk);
    end
    b_req_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
